// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT sequencer.
//   N          coefficients per polynomial
//   LOG_N      RAM address width
//   NUM_LAYERS butterfly layers per transform (len 128..2)
//   W          signed coefficient width
//   TW_W       twiddle ROM index width
package ntt_pkg;

  localparam int N          = 256;
  localparam int LOG_N      = 8;
  localparam int NUM_LAYERS = 7;
  localparam int W          = 16;
  localparam int TW_W       = 7;
  localparam int KYBER_Q    = 3329;

  typedef logic signed [W-1:0] coeff_t;
  typedef logic [LOG_N-1:0]    addr_t;
  typedef logic [TW_W-1:0]     tw_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/ntt_if.sv
// Bus between the NTT sequencer and its environment: host handshake,
// coefficient RAM (two sync-read ports, paired write), twiddle ROM and the
// external butterfly.
//   master : sequencer side (drives addresses, write data, operands)
//   slave  : environment side (RAM, ROM, butterfly, host)
interface ntt_if;
  import ntt_pkg::*;

  logic   start;
  logic   inv;
  logic   busy;
  logic   done;
  addr_t  rd_addr_a;
  addr_t  rd_addr_b;
  coeff_t rd_data_a;
  coeff_t rd_data_b;
  logic   wr_en;
  addr_t  wr_addr_a;
  addr_t  wr_addr_b;
  coeff_t wr_data_a;
  coeff_t wr_data_b;
  tw_t    tw_addr;
  coeff_t tw_data;
  logic   bf_mode;
  coeff_t bf_a;
  coeff_t bf_b;
  coeff_t bf_w;
  coeff_t bf_out_a;
  coeff_t bf_out_b;

  modport master (
    input  start, inv, rd_data_a, rd_data_b, tw_data, bf_out_a, bf_out_b,
    output busy, done, rd_addr_a, rd_addr_b, wr_en, wr_addr_a, wr_addr_b,
           wr_data_a, wr_data_b, tw_addr, bf_mode, bf_a, bf_b, bf_w
  );

  modport slave (
    output start, inv, rd_data_a, rd_data_b, tw_data, bf_out_a, bf_out_b,
    input  busy, done, rd_addr_a, rd_addr_b, wr_en, wr_addr_a, wr_addr_b,
           wr_data_a, wr_data_b, tw_addr, bf_mode, bf_a, bf_b, bf_w
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly pair / twiddle index generator.
// A layer counter and a 7-bit pair counter (0..127) are kept; the group
// index, in-group offset and twiddle index are all derived from them.
//   clk, rst_n       clock, async active-low reset
//   clr              restart at layer 0, pair 0
//   adv              advance one pair (one issue)
//   inv              0: CT order (len 128..2), 1: GS order (len 2..128)
//   addr_a, addr_b   pair addresses (j, j+len)
//   tw_addr          twiddle ROM index for the current group
//   last_in_layer    current pair is the 128th of its layer
//   last_layer       current layer is the final one
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  adv,
  input  logic  inv,
  output addr_t addr_a,
  output addr_t addr_b,
  output tw_t   tw_addr,
  output logic  last_in_layer,
  output logic  last_layer
);

  localparam int CW = LOG_N - 1;

  logic [2:0]    layer;
  logic [CW-1:0] cnt;
  logic [2:0]    shamt;
  logic [CW-1:0] off_mask;
  logic [CW-1:0] grp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= '0;
      cnt   <= '0;
    end else if (clr) begin
      layer <= '0;
      cnt   <= '0;
    end else if (adv) begin
      cnt <= cnt + 1'b1;
      if (&cnt) layer <= layer + 3'd1;
    end
  end

  // len = 1 << shamt. With 128 pairs per layer, the pair counter splits
  // into a group index (upper bits) and an in-group offset (lower shamt
  // bits); the group base address is group * 2len, i.e. the upper bits
  // shifted left by one.
  always_comb begin
    shamt    = inv ? (layer + 3'd1) : (3'd7 - layer);
    off_mask = (CW'(1) << shamt) - CW'(1);
    grp      = cnt >> shamt;
    addr_a   = {cnt & ~off_mask, 1'b0} | {1'b0, cnt & off_mask};
    addr_b   = addr_a + (addr_t'(1) << shamt);
    // CT: layer L has 2^L groups numbered from 2^L (1 then 2,3 then ...).
    // GS: layer L has 2^(6-L) groups counting down from 2^(7-L)-1.
    if (inv) tw_addr = (tw_t'(127) >> layer) - grp;
    else     tw_addr = (tw_t'(1) << layer) + grp;
  end

  assign last_in_layer = &cnt;
  assign last_layer    = (layer == 3'(NUM_LAYERS - 1));

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer for one NTT butterfly datapath over a 256-coefficient
// polynomial in an external RAM. Runs a full forward (CT) or inverse (GS)
// transform; the inverse's final n^-1 scaling is left to a later pass.
//   clk    system clock
//   rst_n  asynchronous active-low reset (aborts a run)
//   bus    ntt_if.master: start/inv/busy/done handshake, RAM read and write
//          ports, twiddle ROM index/data, butterfly operands/results
// Pipeline: p0 issues read and twiddle addresses, p1 sees RAM/ROM data and
// the combinational butterfly result, p2 writes it back to the p0 addresses.
module ntt_ctrl
  import ntt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ntt_if.master bus
);

  state_t state, state_nx;
  logic   drain_cnt;
  logic   fin_q;
  logic   inv_q;
  logic   issue;
  logic   clr;
  logic   busy;
  logic   done;

  addr_t  gen_addr_a, gen_addr_b;
  tw_t    gen_tw;
  logic   gen_last_in_layer, gen_last_layer;

  addr_t  rd_addr_a_p0, rd_addr_b_p0;
  tw_t    tw_addr_p0;
  logic   vld_p1;
  addr_t  addr_a_p1, addr_b_p1;
  logic   vld_p2;
  addr_t  wr_addr_a_p2, wr_addr_b_p2;
  coeff_t wr_data_a_p2, wr_data_b_p2;

  ntt_addr_gen u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .adv           (issue),
    .inv           (inv_q),
    .addr_a        (gen_addr_a),
    .addr_b        (gen_addr_b),
    .tw_addr       (gen_tw),
    .last_in_layer (gen_last_in_layer),
    .last_layer    (gen_last_layer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      fin_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      // Remember whether the layer just issued was the last one, since the
      // generator has already stepped past it by the time DRAIN decides.
      if (issue && gen_last_in_layer) fin_q <= gen_last_layer;
      if (clr) inv_q <= bus.inv;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    clr      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          clr      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (gen_last_in_layer) state_nx = DRAIN;
      end
      DRAIN: begin
        // Two cycles let the layer's last pair reach the RAM before the
        // next layer reads any of it.
        if (drain_cnt) state_nx = fin_q ? FINISH : ISSUE;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- p0: issue read and twiddle addresses ----
  assign rd_addr_a_p0 = issue ? gen_addr_a : '0;
  assign rd_addr_b_p0 = issue ? gen_addr_b : '0;
  assign tw_addr_p0   = issue ? gen_tw     : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      addr_a_p1 <= '0;
      addr_b_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        addr_a_p1 <= rd_addr_a_p0;
        addr_b_p1 <= rd_addr_b_p0;
      end
    end
  end

  // ---- p1: operands valid, butterfly result captured for write ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2       <= 1'b0;
      wr_addr_a_p2 <= '0;
      wr_addr_b_p2 <= '0;
      wr_data_a_p2 <= '0;
      wr_data_b_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        wr_addr_a_p2 <= addr_a_p1;
        wr_addr_b_p2 <= addr_b_p1;
        wr_data_a_p2 <= bus.bf_out_a;
        wr_data_b_p2 <= bus.bf_out_b;
      end
    end
  end

  // ---- p2: write back ----
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_addr_a = rd_addr_a_p0;
  assign bus.rd_addr_b = rd_addr_b_p0;
  assign bus.tw_addr   = tw_addr_p0;
  assign bus.wr_en     = vld_p2;
  assign bus.wr_addr_a = wr_addr_a_p2;
  assign bus.wr_addr_b = wr_addr_b_p2;
  assign bus.wr_data_a = wr_data_a_p2;
  assign bus.wr_data_b = wr_data_b_p2;
  assign bus.bf_mode   = inv_q;
  assign bus.bf_a      = bus.rd_data_a;
  assign bus.bf_b      = bus.rd_data_b;
  assign bus.bf_w      = bus.tw_data;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: RAM, twiddle ROM and butterfly models around the
// sequencer; table of expected per-cycle addresses/strobes plus full
// transform checks against a software NTT and an NTT/INTT round trip.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int Q = KYBER_Q;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ntt_if bus();

  ntt_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int   ram [N];
  int   tw_rom [128];
  int   poly [N];
  int   refp [N];
  logic ld_en = 1'b0;
  int   ld_addr = 0;
  int   ld_data = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    bit inv;
    int cyc;
    int ra, rb, tw;
    bit we;
    int wa, wb;
    bit busy, done;
  } vec_t;
  vec_t vecs[$];

  function automatic int modq(input int x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic int bfly(input int a, input int b, input int w, input bit m, input bit sel);
    int t, oa, ob;
    if (!m) begin
      t  = modq(w * b);
      oa = modq(a + t);
      ob = modq(a - t);
    end else begin
      oa = modq(a + b);
      ob = modq(w * modq(b - a));
    end
    return sel ? ob : oa;
  endfunction

  function automatic int powmod(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic int brv7(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 7; b++) r |= ((k >> b) & 1) << (6 - b);
    return r;
  endfunction

  function automatic vec_t mk(input bit vinv, input int cyc, input int ra, input int rb,
                              input int tw, input bit we, input int wa, input int wb,
                              input bit vbusy, input bit vdone);
    vec_t v;
    v.inv = vinv; v.cyc = cyc; v.ra = ra; v.rb = rb; v.tw = tw;
    v.we = we; v.wa = wa; v.wb = wb; v.busy = vbusy; v.done = vdone;
    return v;
  endfunction

  // Memory models: sync-read RAM/ROM, paired write, plus a bench load port.
  always @(posedge clk) begin
    bus.rd_data_a <= coeff_t'(ram[bus.rd_addr_a]);
    bus.rd_data_b <= coeff_t'(ram[bus.rd_addr_b]);
    bus.tw_data   <= coeff_t'(tw_rom[bus.tw_addr]);
    if (bus.wr_en) begin
      ram[bus.wr_addr_a] <= int'(bus.wr_data_a);
      ram[bus.wr_addr_b] <= int'(bus.wr_data_b);
    end
    if (ld_en) ram[ld_addr] <= ld_data;
  end

  assign bus.bf_out_a = coeff_t'(bfly(int'(bus.bf_a), int'(bus.bf_b), int'(bus.bf_w), bus.bf_mode, 1'b0));
  assign bus.bf_out_b = coeff_t'(bfly(int'(bus.bf_a), int'(bus.bf_b), int'(bus.bf_w), bus.bf_mode, 1'b1));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v);
    string p;
    p = $sformatf("%s_c%0d", v.inv ? "intt" : "ntt", v.cyc);
    chk({p, "_rd_a"}, int'(bus.rd_addr_a), v.ra);
    chk({p, "_rd_b"}, int'(bus.rd_addr_b), v.rb);
    chk({p, "_tw"},   int'(bus.tw_addr),   v.tw);
    chk({p, "_wr_en"}, int'(bus.wr_en),    int'(v.we));
    chk({p, "_busy"}, int'(bus.busy),      int'(v.busy));
    chk({p, "_done"}, int'(bus.done),      int'(v.done));
    if (v.we) begin
      chk({p, "_wr_a"}, int'(bus.wr_addr_a), v.wa);
      chk({p, "_wr_b"}, int'(bus.wr_addr_b), v.wb);
    end
  endtask

  task automatic load_ram();
    for (int i = 0; i < N; i++) begin
      ld_en = 1'b1; ld_addr = i; ld_data = poly[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic sw_ntt();
    int k, z, t;
    for (int i = 0; i < N; i++) refp[i] = poly[i];
    k = 1;
    for (int len = 128; len >= 2; len >>= 1) begin
      for (int s = 0; s < N; s += 2 * len) begin
        z = tw_rom[k];
        k++;
        for (int j = s; j < s + len; j++) begin
          t = modq(z * refp[j + len]);
          refp[j + len] = modq(refp[j] - t);
          refp[j] = modq(refp[j] + t);
        end
      end
    end
  endtask

  task automatic cmp_ram(input string name, input bit scale);
    int bad, first, fgot, fwant, got, want;
    bad = 0; first = -1; fgot = 0; fwant = 0;
    for (int i = 0; i < N; i++) begin
      got  = scale ? modq(ram[i] * 3303) : ram[i];
      want = scale ? poly[i] : refp[i];
      if (got != want) begin
        if (first < 0) begin first = i; fgot = got; fwant = want; end
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d coefficients differ, first at %0d got %0d expected %0d",
               name, bad, first, fgot, fwant);
    end
  endtask

  task automatic run_op(input bit op_inv, input int abort_at, input bit pulse);
    int cyc, done_cnt, busy_bad;
    bit aborted, hit;
    done_cnt = 0; busy_bad = 0; aborted = 1'b0;
    bus.start = 1'b1;
    bus.inv   = op_inv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk(op_inv ? "intt_bf_mode" : "ntt_bf_mode", int'(bus.bf_mode), int'(op_inv));
    while (cyc <= 912) begin
      if (cyc == abort_at) begin
        chk("pre_abort_wr_en", int'(bus.wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  int'(bus.busy),  0);
        chk("abort_done",  int'(bus.done),  0);
        chk("abort_wr_en", int'(bus.wr_en), 0);
        chk("abort_rd_b",  int'(bus.rd_addr_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_busy", int'(bus.busy), 0);
        aborted = 1'b1;
        break;
      end
      hit = pulse && (cyc == 50 || cyc == 500);
      bus.start = hit;
      bus.inv   = hit ? ~op_inv : op_inv;
      foreach (vecs[i])
        if (vecs[i].inv == op_inv && vecs[i].cyc == cyc) check_vec(vecs[i]);
      if (bus.busy !== (cyc <= 911)) busy_bad++;
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.inv   = op_inv;
    if (!aborted) begin
      chk(op_inv ? "intt_busy_window" : "ntt_busy_window", busy_bad, 0);
      chk(op_inv ? "intt_done_count" : "ntt_done_count", done_cnt, 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 128; k++) tw_rom[k] = powmod(17, brv7(k));
    for (int i = 0; i < N; i++) ram[i] = 0;

    //       inv cyc  ra   rb  tw  we  wa   wb  busy done
    vecs.push_back(mk(0,   1,   0, 128,   1, 0,   0,   0, 1, 0));
    vecs.push_back(mk(0,   2,   1, 129,   1, 0,   0,   0, 1, 0));
    vecs.push_back(mk(0,   3,   2, 130,   1, 1,   0, 128, 1, 0));
    vecs.push_back(mk(0, 128, 127, 255,   1, 1, 125, 253, 1, 0));
    vecs.push_back(mk(0, 129,   0,   0,   0, 1, 126, 254, 1, 0));
    vecs.push_back(mk(0, 130,   0,   0,   0, 1, 127, 255, 1, 0));
    vecs.push_back(mk(0, 131,   0,  64,   2, 0,   0,   0, 1, 0));
    vecs.push_back(mk(0, 132,   1,  65,   2, 0,   0,   0, 1, 0));
    vecs.push_back(mk(0, 133,   2,  66,   2, 1,   0,  64, 1, 0));
    vecs.push_back(mk(0, 195, 128, 192,   3, 1,  62, 126, 1, 0));
    vecs.push_back(mk(0, 261,   0,  32,   4, 0,   0,   0, 1, 0));
    vecs.push_back(mk(0, 908, 253, 255, 127, 1, 249, 251, 1, 0));
    vecs.push_back(mk(0, 910,   0,   0,   0, 1, 253, 255, 1, 0));
    vecs.push_back(mk(0, 911,   0,   0,   0, 0,   0,   0, 1, 1));
    vecs.push_back(mk(0, 912,   0,   0,   0, 0,   0,   0, 0, 0));
    vecs.push_back(mk(1,   1,   0,   2, 127, 0,   0,   0, 1, 0));
    vecs.push_back(mk(1,   2,   1,   3, 127, 0,   0,   0, 1, 0));
    vecs.push_back(mk(1,   3,   4,   6, 126, 1,   0,   2, 1, 0));
    vecs.push_back(mk(1, 128, 253, 255,  64, 1, 249, 251, 1, 0));
    vecs.push_back(mk(1, 131,   0,   4,  63, 0,   0,   0, 1, 0));
    vecs.push_back(mk(1, 908, 127, 255,   1, 1, 125, 253, 1, 0));
    vecs.push_back(mk(1, 911,   0,   0,   0, 0,   0,   0, 1, 1));

    bus.start = 1'b0;
    bus.inv   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    int'(bus.busy),      0);
    chk("rst_done",    int'(bus.done),      0);
    chk("rst_wr_en",   int'(bus.wr_en),     0);
    chk("rst_rd_a",    int'(bus.rd_addr_a), 0);
    chk("rst_rd_b",    int'(bus.rd_addr_b), 0);
    chk("rst_tw",      int'(bus.tw_addr),   0);
    chk("rst_wr_b",    int'(bus.wr_addr_b), 0);
    chk("rst_wdata_a", int'(bus.wr_data_a), 0);
    chk("rst_bf_mode", int'(bus.bf_mode),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward NTT with ignored start/inv pulses mid-run, then INTT round trip.
    for (int i = 0; i < N; i++) poly[i] = int'($urandom_range(Q - 1, 0));
    load_ram();
    sw_ntt();
    run_op(1'b0, -1, 1'b1);
    cmp_ram("ntt_golden", 1'b0);
    run_op(1'b1, -1, 1'b0);
    cmp_ram("intt_roundtrip", 1'b1);

    // Abort mid-run, then a clean run on fresh data.
    load_ram();
    run_op(1'b0, 300, 1'b0);
    for (int i = 0; i < N; i++) poly[i] = int'($urandom_range(Q - 1, 0));
    load_ram();
    sw_ntt();
    run_op(1'b0, -1, 1'b0);
    cmp_ram("ntt_after_abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
Sequencer for the single ntt_butterfly datapath; runs a full forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over one 256-coefficient polynomial held in an external coefficient RAM.
Generates read/write addresses, twiddle ROM index and butterfly mode, pipelines operands and results, and signals completion.
INTT final scaling by n^-1 is out of scope; a later pass does it.

Parameters:
N, 256, coefficients per polynomial
LOG_N, 8, address width
NUM_LAYERS, 7, butterfly layers (len 128..2)
W, 16, coefficient width (signed)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch request, sampled only in IDLE
inv  in  1  0=NTT (CT), 1=INTT (GS); latched at start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at completion
rd_addr_a / rd_addr_b  out  LOG_N each  RAM read addresses; sync read, data next cycle
rd_data_a / rd_data_b  in  W each  RAM read data
wr_en  out  1  write both ports this cycle
wr_addr_a / wr_addr_b  out  LOG_N each  RAM write addresses
wr_data_a / wr_data_b  out  W each  RAM write data
tw_addr  out  7  twiddle ROM index; sync ROM, data next cycle
tw_data  in  W  twiddle value
bf_mode  out  1  to butterfly mode (= latched inv)
bf_a / bf_b / bf_w  out  W each  butterfly operands (rd_data_a, rd_data_b, tw_data)
bf_out_a / bf_out_b  in  W each  butterfly results

Behaviour:
- Reset: state=IDLE; busy, done, wr_en=0; all addresses, tw_addr, wr_data=0; bf_mode=0. Async reset mid-run aborts; RAM contents are then undefined to the caller.
- FSM: IDLE -> ISSUE (start=1) ; ISSUE -> DRAIN after 128th issue of layer ; DRAIN -> ISSUE (2 cycles, more layers) or FINISH (last layer) ; FINISH -> IDLE (1 cycle, done=1).
- start while busy ignored; inv changes while busy ignored.
- Layer order: NTT len=128,64,...,2; INTT len=2,4,...,128.
- Within a layer: for each group start s (0, 2len, 4len...), j=s..s+len-1: issue pair (j, j+len); one pair/cycle, 128 pairs/layer.
- Twiddle index k: NTT starts 1, +1 per group, persists across layers (last=127). INTT starts 127, -1 per group (last=1).
- Pipeline: cycle t issue (rd_addr, tw_addr); t+1 rd/tw data valid, butterfly combinational, results captured in write regs at end of t+1; t+2 wr_en=1 with the addresses issued at t. Addresses are pipelined alongside data.
- Reads and writes overlap within a layer (each index touched once per layer, no hazard). DRAIN of 2 cycles guarantees the last write of a layer lands before the first read of the next.
- Timing: start accepted at edge ending cycle 0; layer L (0-based) issues cycles 1+130L .. 128+130L; last write cycle 910; done=1 in cycle 911; busy=1 cycles 1..911.
- wr_en=0 whenever no valid pipelined pair (IDLE, first cycle of ISSUE, after drain).

Decomposition:
- Package ntt_pkg: N, LOG_N, NUM_LAYERS, W, KYBER_Q=3329, typedef coeff_t (signed W), addr_t, state enum {IDLE, ISSUE, DRAIN, FINISH}.
- Sub-module ntt_addr_gen: layer/group/j counters producing (addr_a, addr_b, tw_addr, last_in_layer, last_layer). Controller keeps the FSM and the 2-stage valid/address pipeline.

Test Plan:
- NTT launch: start=1, inv=0 at cycle 0 -> cycle 1 rd 0/128 tw 1; cycle 2 rd 1/129 tw 1; cycle 3 wr_en=1 wr 0/128.
- NTT layer 2: cycle 131 rd 0/64 tw 2; cycle 195 rd 128/192 tw 3; final issue cycle 908 rd 253/255 tw 127; done pulse exactly at cycle 911, busy low at 912.
- INTT launch: inv=1 -> bf_mode=1; cycle 1 rd 0/2 tw 127; cycle 2 rd 1/3 tw 127; cycle 3 rd 4/6 tw 126; last issue rd 127/255 tw 1.
- Golden check: random coefficients in [0,3328] with butterfly + RAM models -> RAM matches software NTT; NTT then INTT then scaling by 3303 (= 128^-1 mod 3329; the scaling is done by the bench) -> original polynomial.
- start pulsed at cycles 50 and 500 during run -> ignored, single done at 911; no wr_en during DRAIN beyond pipelined writes.
- rst_n low at cycle 300 -> busy, done, wr_en zero immediately; after release, new start runs full 911-cycle sequence correctly.
